// File: rtl/sha256_round_rewind.sv
// sha256_round_rewind
//   Iterative SHA-256 round inverter. Starting from the working state after
//   end_round rounds and the 16 most recent schedule words, undoes one round
//   per clock back to stop_round, regenerating older schedule words by running
//   the message-schedule recurrence backwards.
//
//   Optional feature macro: SHA256_REWIND_ARGCHK_EN (start argument checking;
//   rejected starts pulse err). Undefined: err is always 0, every start accepted.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request, sampled when idle (also in the done cycle)
//   state_in     {a,b,c,d,e,f,g,h} after end_round rounds, a in [255:224]
//   w_window_in  slot j = [511-32j -: 32] = W[end_round-1-j]
//   end_round    rounds already applied (0..64)
//   stop_round   target round count (0..end_round)
//   busy         engine occupied
//   done         one-cycle completion pulse
//   state_out    working-state register; result held after done
//   err          one-cycle pulse on a rejected start
module sha256_round_rewind (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] state_in,
   input  logic [511:0] w_window_in,
   input  logic [6:0]   end_round,
   input  logic [6:0]   stop_round,
   output logic         busy,
   output logic         done,
   output logic [255:0] state_out,
   output logic         err
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned SLOTS  = 16;
   localparam int unsigned CNT_W  = 7;

   localparam logic [WORD_W-1:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] big_sig0(input logic [WORD_W-1:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [WORD_W-1:0] big_sig1(input logic [WORD_W-1:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [WORD_W-1:0] small_sig0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] small_sig1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  win_q [SLOTS];
   logic [WORD_W-1:0]  win_d [SLOTS];
   logic [CNT_W-1:0]   cur_q, cur_d;
   logic [CNT_W-1:0]   n_q, n_d;
   logic [255:0]       work_d;
   logic               busy_d, done_d, err_d;

   // Argument check for incoming starts
   logic bad_args_c;
`ifdef SHA256_REWIND_ARGCHK_EN
   assign bad_args_c = (end_round > 7'd64) || (stop_round > end_round);
`else
   assign bad_args_c = 1'b0;
`endif

   // One inverse round on the current working state
   logic [WORD_W-1:0] a_p, b_p, c_p, d_p, e_p, f_p, g_p, h_p;
   logic [WORD_W-1:0] na_c, nb_c, nc_c, nd_c, ne_c, nf_c, ng_c, nh_c;
   logic [WORD_W-1:0] t1_c, t2_c, k_c, w_old_c;
   logic [CNT_W-1:0]  r_c;

   always_comb begin
      {a_p, b_p, c_p, d_p, e_p, f_p, g_p, h_p} = state_out;
      r_c  = cur_q - 7'd1;
      k_c  = K_TAB[r_c[5:0]];
      na_c = b_p;
      nb_c = c_p;
      nc_c = d_p;
      ne_c = f_p;
      nf_c = g_p;
      ng_c = h_p;
      t2_c = big_sig0(na_c) + ((na_c & nb_c) ^ (na_c & nc_c) ^ (nb_c & nc_c));
      t1_c = a_p - t2_c;
      nd_c = e_p - t1_c;
      nh_c = t1_c - big_sig1(ne_c) - ((ne_c & nf_c) ^ (~ne_c & ng_c)) - k_c - win_q[0];
      // W[r-16] recovered from the forward recurrence using pre-shift slots
      w_old_c = win_q[0] - small_sig1(win_q[2]) - win_q[7] - small_sig0(win_q[15]);
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      work_d  = state_out;
      win_d   = win_q;
      cur_d   = cur_q;
      n_d     = n_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (bad_args_c) begin
                  err_d = 1'b1;
               end else begin
                  work_d = state_in;
                  for (int j = 0; j < SLOTS; j++) begin
                     win_d[j] = w_window_in[511 - 32*j -: 32];
                  end
                  cur_d   = end_round;
                  n_d     = end_round - stop_round;
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (n_q == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               work_d = {na_c, nb_c, nc_c, nd_c, ne_c, nf_c, ng_c, nh_c};
               for (int j = 0; j < SLOTS - 1; j++) begin
                  win_d[j] = win_q[j+1];
               end
               win_d[SLOTS-1] = (r_c < 7'd16) ? '0 : w_old_c;
               cur_d  = cur_q - 7'd1;
               n_d    = n_q - 7'd1;
               busy_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         state_out <= '0;
         for (int j = 0; j < SLOTS; j++) begin
            win_q[j] <= '0;
         end
         cur_q <= '0;
         n_q   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         state_out <= work_d;
         win_q     <= win_d;
         cur_q     <= cur_d;
         n_q       <= n_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_sha256_round_rewind.sv
// tb_sha256_round_rewind
//   Directed bench for sha256_round_rewind. Expected states come from a forward
//   SHA-256 compression model of the "abc" block and published constants.
module tb_sha256_round_rewind;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] state_in;
   logic [511:0] w_window_in;
   logic [6:0]   end_round;
   logic [6:0]   stop_round;
   logic         busy;
   logic         done;
   logic [255:0] state_out;
   logic         err;

   int errors = 0;
   int checks = 0;

   sha256_round_rewind dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .state_in    (state_in),
      .w_window_in (w_window_in),
      .end_round   (end_round),
      .stop_round  (stop_round),
      .busy        (busy),
      .done        (done),
      .state_out   (state_out),
      .err         (err)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] H0  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] S_R1 = 256'h5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab;

   logic [31:0]  wm   [64];
   logic [255:0] hist [65];

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] fwd_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [255:0] sub_words(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
      return r;
   endfunction

   // Window whose slot 0 is W[last], slot j is W[last-j]; negative indices zero
   function automatic logic [511:0] mk_win(input int last);
      logic [511:0] v;
      v = '0;
      for (int j = 0; j < 16; j++) begin
         if (last - j >= 0) v[511 - 32*j -: 32] = wm[last - j];
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch a job; report the edge (after edge 0) where done appears and busy cycle count
   task automatic run_job(input logic [255:0] s, input logic [511:0] w, input logic [6:0] er,
                          input logic [6:0] sr, output int de, output int bc);
      @(negedge clk);
      state_in = s; w_window_in = w; end_round = er; stop_round = sr; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bc = busy ? 1 : 0;
      de = -1;
      for (int e = 1; e <= 200 && de < 0; e++) begin
         @(posedge clk); #1;
         if (busy) bc++;
         if (done) de = e;
      end
   endtask

   int de, bc, seen;
   logic [255:0] prev, zs;

   initial begin
      rst = 1'b1; start = 1'b0; state_in = '0; w_window_in = '0; end_round = '0; stop_round = '0;

      // Forward model of the "abc" block
      for (int t = 0; t < 16; t++) wm[t] = 32'h0;
      wm[0]  = 32'h61626380;
      wm[15] = 32'h00000018;
      for (int t = 16; t < 64; t++)
         wm[t] = (rr(wm[t-2], 17) ^ rr(wm[t-2], 19) ^ (wm[t-2] >> 10)) + wm[t-7]
               + (rr(wm[t-15], 7) ^ rr(wm[t-15], 18) ^ (wm[t-15] >> 3)) + wm[t-16];
      hist[0] = H0;
      for (int t = 0; t < 64; t++) hist[t+1] = fwd_round(hist[t], KT[t], wm[t]);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_state", state_out, 256'(0));
      chk("model_round1", hist[1], S_R1);
      chk("model_final", hist[64], sub_words(DIG, H0));
      @(negedge clk);
      rst = 1'b0;

      // Undo round 0 of "abc"
      run_job(S_R1, {32'h61626380, 480'h0}, 7'd1, 7'd0, de, bc);
      chk("r0_state", state_out, H0);
      chk("r0_done_edge", 256'(de), 256'(2));
      @(posedge clk); #1;
      chk("r0_done_pulse", 256'(done), 256'(0));

      // Full 64 -> 0 rewind
      run_job(sub_words(DIG, H0), mk_win(63), 7'd64, 7'd0, de, bc);
      chk("full_state", state_out, H0);
      chk("full_done_edge", 256'(de), 256'(65));
      chk("full_busy_cycles", 256'(bc), 256'(65));

      // Partial 64 -> 20
      run_job(sub_words(DIG, H0), mk_win(63), 7'd64, 7'd20, de, bc);
      chk("part_state", state_out, hist[20]);
      chk("part_busy_cycles", 256'(bc), 256'(45));
      chk("part_done_edge", 256'(de), 256'(45));

      // Mid-range 30 -> 10, crosses into rounds below 16
      run_job(hist[30], mk_win(29), 7'd30, 7'd10, de, bc);
      chk("mid_state", state_out, hist[10]);
      chk("mid_done_edge", 256'(de), 256'(21));

      // Zero-step at 37 with a second start held during busy
      zs = 256'h0123456789abcdef_fedcba9876543210_deadbeefcafef00d_0badc0de12345678;
      @(negedge clk);
      state_in = zs; w_window_in = {16{32'h13579bdf}}; end_round = 7'd37; stop_round = 7'd37; start = 1'b1;
      @(posedge clk); #1;
      chk("zero_busy_e0", 256'(busy), 256'(1));
      state_in = ~zs; stop_round = 7'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_done_e1", 256'(done), 256'(1));
      chk("zero_busy_e1", 256'(busy), 256'(0));
      chk("zero_state", state_out, zs);
      @(posedge clk); #1;
      chk("zero_ignored_busy", 256'(busy), 256'(0));
      chk("zero_ignored_state", state_out, zs);

      // Out-of-range end_round
      prev = state_out;
      @(negedge clk);
      state_in = H0; w_window_in = '0; end_round = 7'd65; stop_round = 7'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
`ifdef SHA256_REWIND_ARGCHK_EN
      chk("inv_err", 256'(err), 256'(1));
      chk("inv_busy", 256'(busy), 256'(0));
      chk("inv_state", state_out, prev);
      @(posedge clk); #1;
      chk("inv_err_pulse", 256'(err), 256'(0));
      chk("inv_busy_after", 256'(busy), 256'(0));
`else
      chk("inv_err", 256'(err), 256'(0));
      seen = 0;
      for (int e = 1; e <= 140 && seen == 0; e++) begin
         @(posedge clk); #1;
         if (err) seen = 2;
         else if (done) seen = 1;
      end
      chk("inv_returns_idle", 256'(seen), 256'(1));
      @(posedge clk); #1;
      chk("inv_busy_after", 256'(busy), 256'(0));
`endif

      // Reset at edge 10 of a 64-step run
      @(negedge clk);
      state_in = sub_words(DIG, H0); w_window_in = mk_win(63); end_round = 7'd64; stop_round = 7'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 256'(busy), 256'(0));
      chk("abort_done", 256'(done), 256'(0));
      chk("abort_state", state_out, 256'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle_done", 256'(done), 256'(0));
      run_job(sub_words(DIG, H0), mk_win(63), 7'd64, 7'd0, de, bc);
      chk("rerun_state", state_out, H0);
      chk("rerun_done_edge", 256'(de), 256'(65));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
